// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared definitions: default geometry, entry layout
// and the tag type for the default depth.
package rob_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_RD_W   = 5;

    typedef logic [$clog2(ROB_DEPTH)-1:0] rob_tag_t;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [ROB_RD_W-1:0]   rd;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: dispatch allocation, CDB writeback, commit
// handshake, flush and occupancy status.
//   master : core side (dispatch / execute / register file)
//   slave  : the reorder buffer
interface reorder_buffer_if
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int DATA_W = ROB_DATA_W,
    parameter int RD_W   = ROB_RD_W
);
    localparam int TAG_W = $clog2(DEPTH);

    logic              alloc;
    logic [RD_W-1:0]   alloc_rd;
    logic [TAG_W-1:0]  alloc_tag;
    logic              full;
    logic              empty;
    logic [TAG_W:0]    count;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              commit_valid;
    logic              commit_ready;
    logic [TAG_W-1:0]  commit_tag;
    logic [RD_W-1:0]   commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic              flush;

    modport master (
        output alloc, alloc_rd, wb_valid, wb_tag, wb_data, commit_ready, flush,
        input  alloc_tag, full, empty, count,
        input  commit_valid, commit_tag, commit_rd, commit_data
    );

    modport slave (
        input  alloc, alloc_rd, wb_valid, wb_tag, wb_data, commit_ready, flush,
        output alloc_tag, full, empty, count,
        output commit_valid, commit_tag, commit_rd, commit_data
    );

endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocate at the tail, out-of-order completion
// by tag, in-order retirement from the head via a valid/ready handshake.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : reorder_buffer_if.slave (alloc, writeback, commit, flush, status)
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int DATA_W = ROB_DATA_W,
    parameter int RD_W   = ROB_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave bus
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           ent [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic full;
    logic alloc_fire;
    logic commit_fire;
    logic wb_fire;

    assign full        = (count == CNT_W'(DEPTH));
    assign alloc_fire  = bus.alloc && !full;
    assign commit_fire = ent[head].valid && ent[head].done && bus.commit_ready;
    // A writeback aimed at the retiring head is dropped so the retired
    // entry is cleared cleanly rather than rewritten.
    assign wb_fire     = bus.wb_valid && ent[bus.wb_tag].valid &&
                         !(commit_fire && (bus.wb_tag == head));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            // rd/data are left stale; valid/done alone define occupancy.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].done  <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wb_fire) begin
                ent[bus.wb_tag].done <= 1'b1;
                ent[bus.wb_tag].data <= bus.wb_data;
            end
            if (commit_fire) begin
                ent[head].valid <= 1'b0;
                ent[head].done  <= 1'b0;
                head            <= head + TAG_W'(1);
            end
            // Tail never equals a live head here: alloc needs !full and
            // commit needs a non-empty buffer.
            if (alloc_fire) begin
                ent[tail].valid <= 1'b1;
                ent[tail].done  <= 1'b0;
                ent[tail].rd    <= bus.alloc_rd;
                ent[tail].data  <= '0;
                tail            <= tail + TAG_W'(1);
            end
            unique case ({alloc_fire, commit_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.alloc_tag    = tail;
    assign bus.full         = full;
    assign bus.empty        = (count == '0);
    assign bus.count        = count;
    assign bus.commit_valid = ent[head].valid && ent[head].done;
    assign bus.commit_tag   = head;
    assign bus.commit_rd    = ent[head].rd;
    assign bus.commit_data  = ent[head].data;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a vector table for fill,
// out-of-order completion and backpressure, hand-written sequences for
// wrap-around, simultaneous events and flush, then randomized traffic
// checked against a queue-based reference model.
module tb_reorder_buffer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reorder_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the in-flight instructions in program order.
    typedef struct {
        int          tag;
        int          rd;
        bit          done;
        logic [31:0] data;
    } ment_t;

    ment_t mq[$];
    int    m_next = 0;

    function automatic bit m_cv();
        return (mq.size() > 0) && mq[0].done;
    endfunction

    function automatic int m_head();
        return (mq.size() > 0) ? mq[0].tag : m_next;
    endfunction

    task automatic model_edge();
        bit cf;
        bit af;
        if (rst || bus.flush) begin
            mq.delete();
            m_next = 0;
            return;
        end
        cf = m_cv() && bus.commit_ready;
        af = bus.alloc && (mq.size() < DEPTH);
        if (bus.wb_valid) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(bus.wb_tag) && !(cf && i == 0)) begin
                    mq[i].done = 1'b1;
                    mq[i].data = bus.wb_data;
                end
            end
        end
        if (cf) void'(mq.pop_front());
        if (af) begin
            mq.push_back('{m_next, int'(bus.alloc_rd), 1'b0, 32'h0});
            m_next = (m_next + 1) % DEPTH;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name);
        check({name, ".count"}, 64'(bus.count), 64'(mq.size()));
        check({name, ".full"}, 64'(bus.full), 64'(mq.size() == DEPTH));
        check({name, ".empty"}, 64'(bus.empty), 64'(mq.size() == 0));
        check({name, ".alloc_tag"}, 64'(bus.alloc_tag), 64'(m_next));
        check({name, ".commit_valid"}, 64'(bus.commit_valid), 64'(m_cv()));
        check({name, ".commit_tag"}, 64'(bus.commit_tag), 64'(m_head()));
        if (m_cv()) begin
            check({name, ".commit_rd"}, 64'(bus.commit_rd), 64'(mq[0].rd));
            check({name, ".commit_data"}, 64'(bus.commit_data), 64'(mq[0].data));
        end
    endtask

    // One clock: inputs are already stable; model and DUT advance on the
    // same edge, outputs are sampled 1 time unit later.
    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        #1;
        check_all(name);
    endtask

    task automatic drive(input logic a, input int rd, input logic wv, input int wt,
                         input logic [31:0] wd, input logic rdy, input logic fl);
        bus.alloc        = a;
        bus.alloc_rd     = RD_W'(rd);
        bus.wb_valid     = wv;
        bus.wb_tag       = 3'(wt);
        bus.wb_data      = wd;
        bus.commit_ready = rdy;
        bus.flush        = fl;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        logic        alloc;
        int          rd;
        logic        wbv;
        int          wbt;
        logic [31:0] wbd;
        logic        rdy;
        int          pre_tag;   // -1: granted tag not checked
        int          count;
        logic        full;
        logic        empty;
        logic        cv;
        int          ctag;
        int          crd;
        logic [31:0] cdata;
    } vec_t;

    function automatic vec_t mk(input logic a, input int rd, input logic wv, input int wt,
                                input logic [31:0] wd, input logic rdy, input int pt,
                                input int cnt, input logic fu, input logic em,
                                input logic cv, input int ct, input int cr,
                                input logic [31:0] cd);
        vec_t v;
        v.alloc = a;   v.rd = rd;    v.wbv = wv;   v.wbt = wt;   v.wbd = wd;
        v.rdy = rdy;   v.pre_tag = pt; v.count = cnt; v.full = fu; v.empty = em;
        v.cv = cv;     v.ctag = ct;  v.crd = cr;   v.cdata = cd;
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        idle();

        // Fill, overflow, out-of-order completion, in-order retire, backpressure.
        for (int i = 0; i < DEPTH; i++)
            vq.push_back(mk(1, i + 1, 0, 0, 0, 0, i, i + 1, i == DEPTH - 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 9, 0, 0, 0,     0, -1, 8, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 3, 'h30,  1, -1, 8, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 'h10,  1, -1, 8, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 'h00,  1, -1, 8, 1, 0, 1, 0, 1, 'h00));
        vq.push_back(mk(0, 0, 1, 2, 'h20,  1, -1, 7, 0, 0, 1, 1, 2, 'h10));
        vq.push_back(mk(0, 0, 0, 0, 0,     1, -1, 6, 0, 0, 1, 2, 3, 'h20));
        vq.push_back(mk(0, 0, 0, 0, 0,     1, -1, 5, 0, 0, 1, 3, 4, 'h30));
        vq.push_back(mk(0, 0, 0, 0, 0,     1, -1, 4, 0, 0, 0, 4, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,     1, -1, 4, 0, 0, 0, 4, 0, 0));
        vq.push_back(mk(0, 0, 1, 4, 'h44,  0, -1, 4, 0, 0, 1, 4, 5, 'h44));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(0, 0, 0, 0, 0, 0, -1, 4, 0, 0, 1, 4, 5, 'h44));
        vq.push_back(mk(0, 0, 0, 0, 0,     1, -1, 3, 0, 0, 0, 5, 0, 0));

        do_reset();
        check("rst.empty", 64'(bus.empty), 64'(1));
        check("rst.full", 64'(bus.full), 64'(0));
        check("rst.count", 64'(bus.count), 64'(0));
        check("rst.commit_valid", 64'(bus.commit_valid), 64'(0));
        check("rst.commit_tag", 64'(bus.commit_tag), 64'(0));
        check("rst.commit_rd", 64'(bus.commit_rd), 64'(0));
        check("rst.commit_data", 64'(bus.commit_data), 64'(0));
        check("rst.alloc_tag", 64'(bus.alloc_tag), 64'(0));

        foreach (vq[k]) begin
            drive(vq[k].alloc, vq[k].rd, vq[k].wbv, vq[k].wbt, vq[k].wbd, vq[k].rdy, 1'b0);
            if (vq[k].pre_tag >= 0)
                check("vec.granted_tag", 64'(bus.alloc_tag), 64'(vq[k].pre_tag));
            step("vec.model");
            check("vec.count", 64'(bus.count), 64'(vq[k].count));
            check("vec.full", 64'(bus.full), 64'(vq[k].full));
            check("vec.empty", 64'(bus.empty), 64'(vq[k].empty));
            check("vec.commit_valid", 64'(bus.commit_valid), 64'(vq[k].cv));
            check("vec.commit_tag", 64'(bus.commit_tag), 64'(vq[k].ctag));
            if (vq[k].cv) begin
                check("vec.commit_rd", 64'(bus.commit_rd), 64'(vq[k].crd));
                check("vec.commit_data", 64'(bus.commit_data), 64'(vq[k].cdata));
            end
        end
        idle();

        // Wrap-around: 6 through the buffer, then 5 more straddle the end.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 10 + i, 0, 0, 0, 0, 0);
            step("wrap.alloc");
        end
        for (int t = 0; t < 6; t++) begin
            drive(0, 0, 1, t, 32'h100 + 32'(t), 0, 0);
            step("wrap.wb");
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            step("wrap.commit");
        end
        check("wrap.drained", 64'(bus.empty), 64'(1));
        for (int i = 0; i < 5; i++) begin
            drive(1, 20 + i, 0, 0, 0, 0, 0);
            check("wrap.granted_tag", 64'(bus.alloc_tag), 64'((6 + i) % DEPTH));
            step("wrap.alloc2");
        end
        idle();
        check("wrap.count", 64'(bus.count), 64'(5));
        check("wrap.empty", 64'(bus.empty), 64'(0));
        check("wrap.full", 64'(bus.full), 64'(0));

        // Simultaneous alloc + commit with 4 entries, head done.
        drive(0, 0, 1, 6, 32'h66, 0, 0); step("sim.wb6");
        drive(0, 0, 1, 7, 32'h77, 0, 0); step("sim.wb7");
        drive(0, 0, 0, 0, 0, 1, 0);      step("sim.commit6");
        check("sim.pre_count", 64'(bus.count), 64'(4));
        check("sim.pre_cv", 64'(bus.commit_valid), 64'(1));
        drive(1, 3, 0, 0, 0, 1, 0);
        check("sim.granted_tag", 64'(bus.alloc_tag), 64'(3));
        step("sim.both");
        check("sim.count_same", 64'(bus.count), 64'(4));
        check("sim.next_tag", 64'(bus.alloc_tag), 64'(4));

        // Full buffer with alloc + commit: only the commit fires.
        drive(0, 0, 1, 0, 32'hA0, 0, 0); step("sim.wb0");
        for (int i = 0; i < 4; i++) begin
            drive(1, 4 + i, 0, 0, 0, 0, 0);
            step("sim.fill");
        end
        check("sim.full", 64'(bus.full), 64'(1));
        drive(1, 30, 0, 0, 0, 1, 0);
        step("sim.full_both");
        check("sim.full_count", 64'(bus.count), 64'(7));
        check("sim.full_cleared", 64'(bus.full), 64'(0));
        check("sim.full_tail", 64'(bus.alloc_tag), 64'(0));
        check("sim.full_head", 64'(bus.commit_tag), 64'(1));
        idle();

        // Flush mid-stream beats simultaneous alloc, writeback and commit.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 20 + i, 0, 0, 0, 0, 0);
            step("fl.alloc");
        end
        drive(0, 0, 1, 1, 32'h11, 0, 0); step("fl.wb1");
        drive(0, 0, 1, 3, 32'h33, 0, 0); step("fl.wb3");
        drive(1, 31, 1, 0, 32'hAA, 1, 1);
        step("fl.flush");
        check("fl.empty", 64'(bus.empty), 64'(1));
        check("fl.count", 64'(bus.count), 64'(0));
        check("fl.commit_valid", 64'(bus.commit_valid), 64'(0));
        check("fl.alloc_tag", 64'(bus.alloc_tag), 64'(0));
        drive(1, 1, 0, 0, 0, 0, 0);      step("fl.realloc0");
        drive(0, 0, 1, 3, 32'hBB, 0, 0); step("fl.stale_wb");
        for (int i = 0; i < 3; i++) begin
            drive(1, 2 + i, 0, 0, 0, 0, 0);
            step("fl.realloc");
        end
        for (int t = 0; t < 3; t++) begin
            drive(0, 0, 1, t, 32'hC0 + 32'(t), 0, 0);
            step("fl.wb");
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            step("fl.commit");
        end
        check("fl.stale_ignored", 64'(bus.commit_valid), 64'(0));
        check("fl.head3", 64'(bus.commit_tag), 64'(3));
        check("fl.count1", 64'(bus.count), 64'(1));
        idle();

        // Randomized traffic, including occasional flush and mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            int wt;
            if (mq.size() > 0 && $urandom_range(0, 9) < 7)
                wt = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                wt = int'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                  1'($urandom_range(0, 9) < 6), wt, $urandom(),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) < 2));
            rst = ($urandom_range(0, 199) == 0);
            step("rand");
        end
        rst = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
